// File: rtl/truth_table_sequencer.sv
// Sweeps every input vector of an NIN-input combinational function and records its truth table.
// Each vector is held for a captured dwell time, and the finished table is compared against an expected table.
module truth_table_sequencer #(
  parameter int NIN     = 3,
  parameter int DWELL_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DWELL_W-1:0]   dwell,
  input  logic [2**NIN-1:0]    exp_table,
  input  logic                 f_in,
  output logic [NIN-1:0]       x_out,
  output logic                 busy,
  output logic                 done,
  output logic [2**NIN-1:0]    table_out,
  output logic                 table_valid,
  output logic                 mismatch
);

  localparam int TW = 2**NIN;

  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

  state_t             state_q, state_d;
  logic [NIN-1:0]     x_q, x_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [TW-1:0]      table_q, table_d;
  logic               valid_q, valid_d;
  logic               mismatch_q, mismatch_d;

  logic               hold_end;
  logic               last_vec;
  logic [TW-1:0]      sampled;

  // dwell_q is never zero in APPLY, so dwell_q-1 cannot underflow there
  assign hold_end = (state_q == APPLY) && (cnt_q == dwell_q - DWELL_W'(1));
  assign last_vec = hold_end && (x_q == {NIN{1'b1}});

  always_comb begin
    sampled = table_q;
    sampled[x_q] = f_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = APPLY;
      APPLY: begin
        if (abort)         state_d = IDLE;
        else if (last_vec) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == APPLY);
    done = (state_q == DONE);
  end

  // Abort takes priority over the sample that would otherwise end the hold
  always_comb begin
    x_d        = x_q;
    cnt_d      = cnt_q;
    dwell_d    = dwell_q;
    table_d    = table_q;
    valid_d    = valid_q;
    mismatch_d = mismatch_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          dwell_d    = (dwell == '0) ? DWELL_W'(1) : dwell;
          x_d        = '0;
          cnt_d      = '0;
          table_d    = '0;
          valid_d    = 1'b0;
          mismatch_d = 1'b0;
        end
      end
      APPLY: begin
        if (abort) begin
          x_d     = '0;
          cnt_d   = '0;
          valid_d = 1'b0;
        end else if (hold_end) begin
          table_d = sampled;
          cnt_d   = '0;
          if (last_vec) begin
            valid_d    = 1'b1;
            mismatch_d = (sampled != exp_table);
          end else begin
            x_d = x_q + NIN'(1);
          end
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= '0;
      cnt_q      <= '0;
      dwell_q    <= '0;
      table_q    <= '0;
      valid_q    <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      x_q        <= x_d;
      cnt_q      <= cnt_d;
      dwell_q    <= dwell_d;
      table_q    <= table_d;
      valid_q    <= valid_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign x_out       = x_q;
  assign table_out   = table_q;
  assign table_valid = valid_q;
  assign mismatch    = mismatch_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer: full sweeps, ignored restarts, aborts and asynchronous reset.
// The function under control is modelled as a lookup into a bench-held truth table.
module tb_truth_table_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [3:0] dwell;
  logic [7:0] exp_table;
  logic       f_in;
  logic [2:0] x_out;
  logic       busy;
  logic       done;
  logic [7:0] table_out;
  logic       table_valid;
  logic       mismatch;

  logic [7:0] func_table;
  int         total;
  int         bad;

  truth_table_sequencer #(.NIN(3), .DWELL_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .dwell       (dwell),
    .exp_table   (exp_table),
    .f_in        (f_in),
    .x_out       (x_out),
    .busy        (busy),
    .done        (done),
    .table_out   (table_out),
    .table_valid (table_valid),
    .mismatch    (mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb f_in = func_table[x_out];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    if (obs !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  // Starts a sweep at a negedge and follows it edge by edge; optional restart, abort-with-start and start-in-DONE
  task automatic applyStimulus(input int d, input logic [7:0] func, input logic [7:0] exp_tab,
                               input logic [7:0] want_tab, input logic want_mis,
                               input int repulse_at, input bit start_in_done, input bit abort_at_start);
    int dd;
    dd = (d == 0) ? 1 : d;
    @(negedge clk);
    func_table = func;
    exp_table  = exp_tab;
    dwell      = 4'(d);
    start      = 1'b1;
    abort      = abort_at_start;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checkOutput("accept_busy", 32'(busy), 32'd1);
    checkOutput("accept_x", 32'(x_out), 32'd0);
    checkOutput("accept_valid", 32'(table_valid), 32'd0);
    for (int j = 1; j <= 8 * dd; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (j < 8 * dd) begin
        checkOutput("run_done", 32'(done), 32'd0);
        checkOutput("run_busy", 32'(busy), 32'd1);
        checkOutput("run_x", 32'(x_out), 32'(j / dd));
        start = (j == repulse_at);
        if (j == repulse_at) dwell = 4'd1;
      end
    end
    start = 1'b0;
    checkOutput("end_done", 32'(done), 32'd1);
    checkOutput("end_busy", 32'(busy), 32'd0);
    checkOutput("end_valid", 32'(table_valid), 32'd1);
    checkOutput("end_table", 32'(table_out), 32'(want_tab));
    checkOutput("end_mismatch", 32'(mismatch), 32'(want_mis));
    checkOutput("end_x", 32'(x_out), 32'd7);
    start = start_in_done;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkOutput("after_done", 32'(done), 32'd0);
    checkOutput("after_busy", 32'(busy), 32'd0);
    checkOutput("after_x", 32'(x_out), 32'd7);
    checkOutput("after_valid", 32'(table_valid), 32'd1);
    checkOutput("after_table", 32'(table_out), 32'(want_tab));
  endtask

  // Dwell 1 sweep aborted while x_out == abort_x; the bit for abort_x must not be sampled
  task automatic abortSweep(input logic [7:0] func, input int abort_x, input logic [7:0] want_tab);
    @(negedge clk);
    func_table = func;
    dwell      = 4'd1;
    start      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int j = 1; j <= abort_x; j++) begin
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("pre_abort_x", 32'(x_out), 32'(abort_x));
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_valid", 32'(table_valid), 32'd0);
    checkOutput("abort_x", 32'(x_out), 32'd0);
    checkOutput("abort_table", 32'(table_out), 32'(want_tab));
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_done2", 32'(done), 32'd0);
    checkOutput("abort_busy2", 32'(busy), 32'd0);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    dwell      = 4'd0;
    exp_table  = 8'h00;
    func_table = 8'h00;
    #12;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_x", 32'(x_out), 32'd0);
    checkOutput("rst_table", 32'(table_out), 32'd0);
    checkOutput("rst_valid", 32'(table_valid), 32'd0);
    checkOutput("rst_mismatch", 32'(mismatch), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // majority, dwell 2, matches expected
    applyStimulus(2, 8'hE8, 8'hE8, 8'hE8, 1'b0, -1, 1'b0, 1'b0);
    // xor, dwell 0 treated as 1, mismatches majority table
    applyStimulus(0, 8'h96, 8'hE8, 8'h96, 1'b1, -1, 1'b0, 1'b0);
    // dwell 3 with start re-pulsed and dwell changed at x_out == 4
    applyStimulus(3, 8'hE8, 8'hE8, 8'hE8, 1'b0, 12, 1'b0, 1'b0);
    // start during DONE is ignored; abort with start in IDLE still accepts
    applyStimulus(1, 8'h96, 8'h96, 8'h96, 1'b0, -1, 1'b1, 1'b1);

    // abort at x_out == 5 keeps bits 0..4 of E8
    abortSweep(8'hE8, 5, 8'h08);
    // abort coincident with final sample keeps bits 0..6 of 96
    abortSweep(8'h96, 7, 8'h16);

    // asynchronous reset mid-sweep
    @(negedge clk);
    func_table = 8'hE8;
    dwell      = 4'd2;
    start      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_x", 32'(x_out), 32'd0);
    checkOutput("arst_table", 32'(table_out), 32'd0);
    checkOutput("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2, 8'hE8, 8'h96, 8'hE8, 1'b1, -1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
